writeback_stage: RTL and testbench
==================================

Name: writeback_stage

Overview:
- Final pipeline stage of the MIPS core, directly upstream of the register file.
- Latches one instruction from the memory stage through a valid/allow handshake.
- For loads, waits for the data-SRAM response, then aligns and extends the load data.
- Drives the register-file write port (enable, address, 4-bit byte strobe, data) and publishes bypass and hazard information to decode.

Parameters:
- PC_RESET, 32'hBFC0_0000, value of the held PC after reset.

Ports:
- clock  in  1  core clock; all state updates on posedge
- reset_n  in  1  asynchronous active-low reset
- ms_to_ws_valid  in  1  memory stage presents an instruction
- ws_allow_in  out  1  stage can accept an instruction this cycle
- ms_pc  in  32  instruction PC
- ms_dest  in  5  destination register; 0 means no write
- ms_result  in  32  ALU/move result for non-load instructions
- ms_load_op  in  3  0 none, 1 LB, 2 LBU, 3 LH, 4 LHU, 5 LW, 6 LWL, 7 LWR
- ms_addr_low  in  2  byte offset of the load address
- data_data_ok  in  1  data-SRAM response strobe for the held load
- data_rdata  in  32  raw load word
- rf_write_enabled  out  1  register-file write enable
- rf_write_address  out  5  register-file write address
- rf_write_strobe  out  4  byte write strobe
- rf_write_data  out  32  aligned write data
- ws_bypass_valid  out  1  held instruction writes a register and its data is final
- ws_bypass_dest  out  5  destination of the held instruction (0 if stage empty)
- ws_load_pending  out  1  held load is still waiting for data_data_ok

Behaviour:
- Reset values:
  - Internal: ws_valid=0, held pc=PC_RESET, dest=0, load_op=0, data_captured=0.
  - Outputs: rf_write_enabled=0, rf_write_address=0, rf_write_strobe=0, rf_write_data=0, ws_bypass_valid=0, ws_bypass_dest=0, ws_load_pending=0.
  - ws_allow_in=1.
- Readiness:
  - ws_ready_go = (load_op==0) | data_captured | data_data_ok.
  - ws_allow_in = !ws_valid | ws_ready_go.
- Acceptance: when ms_to_ws_valid & ws_allow_in at a clock edge:
  - Latch pc, dest, result, load_op, addr_low.
  - Set ws_valid=1 and clear data_captured.
- Emptying: if ws_allow_in & !ms_to_ws_valid, ws_valid <= 0.
- Load capture: when ws_valid & load_op!=0 & data_data_ok & !data_captured:
  - Latch data_rdata into an internal buffer and set data_captured=1.
  - A data_data_ok arriving while ws_valid=0 or while the held op is not a load is ignored.
- Write (combinational from held state):
  - rf_write_enabled = ws_valid & ws_ready_go & (dest!=0).
  - Exactly one write cycle per instruction, because the entry leaves on the same edge.
  - Load word source = data_data_ok ? data_rdata : buffered word. The buffered word is used only when data_captured=1.
- Strobe/data by load_op, with a = addr_low and w = load word:
  - none: strobe 1111, data = result.
  - LB/LBU: byte w[8a+7:8a], sign/zero extended to 32 bits; strobe 1111.
  - LH/LHU: half w[16(a>>1)+15:16(a>>1)], extended; strobe 1111. a[0] is ignored (alignment faults are trapped upstream).
  - LW: w; strobe 1111.
  - LWL: a=0 strobe 1000 data w<<24; a=1 1100 w<<16; a=2 1110 w<<8; a=3 1111 w.
  - LWR: a=0 strobe 1111 data w; a=1 0111 w>>8; a=2 0011 w>>16; a=3 0001 w>>24.
  - rf_write_strobe=0 whenever rf_write_enabled=0.
- Hazard outputs:
  - ws_bypass_dest = ws_valid ? dest : 0.
  - ws_bypass_valid = rf_write_enabled & (load_op ∉ {6,7}). LWL/LWR are merge writes, so decode must stall, not forward.
  - ws_load_pending = ws_valid & load_op!=0 & !data_captured & !data_data_ok.
- Back-to-back: a new instruction may be accepted on the same edge the previous one writes. There is no bubble.
- Reset mid-load:
  - ws_valid and data_captured clear immediately (asynchronous).
  - The write is lost; a late data_data_ok is ignored.

Optional Feature:
- Macro: WRITEBACK_DEBUG_TRACE_EN.
- When defined, adds four outputs:
  - debug_wb_pc (32) = held pc.
  - debug_wb_rf_wen (4) = rf_write_strobe.
  - debug_wb_rf_wnum (5) = rf_write_address.
  - debug_wb_rf_wdata (32) = rf_write_data.
- Also adds a 32-bit retired-instruction counter, reset to 0, incremented once per instruction leaving the stage (ws_valid & ws_ready_go), wrapping at 2^32. It is exposed as debug_retired_count.
- When undefined: these ports and the counter do not exist, and the rest of the behaviour is unchanged.

Test Plan:
- Non-load: ms_result=0x1234_5678, dest=5, load_op=0 -> next cycle rf_write_enabled=1, addr 5, strobe 1111, data 0x1234_5678; ws_allow_in stays 1.
- LB with a=3, rdata=0x80AA_BBCC, data_ok same cycle as entry -> data 0xFFFF_FF80, strobe 1111; LBU with the same inputs -> data 0x0000_0080.
- LW whose data_ok arrives 3 cycles after entry -> ws_allow_in=0 and ws_load_pending=1 for 3 cycles, then a single write of rdata; a following instruction is accepted on the write edge.
- LWL a=1, rdata=0x1122_3344 -> strobe 1100, data 0x3344_0000, ws_bypass_valid=0; LWR a=2 -> strobe 0011, data 0x0000_1122.
- dest=0 load with data_ok -> rf_write_enabled=0 and strobe 0; the stage still empties.
- reset_n asserted while a load is pending -> all outputs reach their reset values immediately; a data_ok one cycle after reset release produces no write.

Source files
------------

// File: rtl/writeback_stage.sv
// ---------------------------------------------------------------------------
// writeback_stage
//
// Final pipeline stage of the MIPS core, sitting directly in front of the
// register file. It holds one instruction handed over by the memory stage,
// waits for the data-SRAM response when that instruction is a load, aligns
// and extends the load data, and drives the register-file write port. It also
// tells decode which register it is about to write and whether the value can
// be forwarded yet.
//
// Parameters:
//   PC_RESET            value of the held PC after reset
//
// Ports:
//   clock               core clock, all state updates on posedge
//   reset_n             asynchronous active-low reset
//   ms_to_ws_valid      memory stage presents an instruction
//   ws_allow_in         stage can accept an instruction this cycle
//   ms_pc/ms_dest/ms_result/ms_load_op/ms_addr_low
//                       instruction fields from the memory stage
//   data_data_ok        data-SRAM response strobe for the held load
//   data_rdata          raw load word
//   rf_write_*          register-file write port (enable, address, strobe, data)
//   ws_bypass_valid     held instruction writes a register with final data
//   ws_bypass_dest      destination of the held instruction (0 when empty)
//   ws_load_pending     held load still waiting for data_data_ok
//
// Optional feature (macro WRITEBACK_DEBUG_TRACE_EN):
//   debug_wb_pc, debug_wb_rf_wen, debug_wb_rf_wnum, debug_wb_rf_wdata trace
//   ports plus debug_retired_count, a wrapping count of retired instructions.
// ---------------------------------------------------------------------------
module writeback_stage #(
    parameter logic [31:0] PC_RESET = 32'hBFC0_0000
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        ms_to_ws_valid,
    output logic        ws_allow_in,
    input  logic [31:0] ms_pc,
    input  logic [4:0]  ms_dest,
    input  logic [31:0] ms_result,
    input  logic [2:0]  ms_load_op,
    input  logic [1:0]  ms_addr_low,
    input  logic        data_data_ok,
    input  logic [31:0] data_rdata,
    output logic        rf_write_enabled,
    output logic [4:0]  rf_write_address,
    output logic [3:0]  rf_write_strobe,
    output logic [31:0] rf_write_data,
    output logic        ws_bypass_valid,
    output logic [4:0]  ws_bypass_dest,
    output logic        ws_load_pending
`ifdef WRITEBACK_DEBUG_TRACE_EN
    ,
    output logic [31:0] debug_wb_pc,
    output logic [3:0]  debug_wb_rf_wen,
    output logic [4:0]  debug_wb_rf_wnum,
    output logic [31:0] debug_wb_rf_wdata,
    output logic [31:0] debug_retired_count
`endif
);

    localparam logic [2:0] OP_NONE = 3'd0;
    localparam logic [2:0] OP_LB   = 3'd1;
    localparam logic [2:0] OP_LBU  = 3'd2;
    localparam logic [2:0] OP_LH   = 3'd3;
    localparam logic [2:0] OP_LHU  = 3'd4;
    localparam logic [2:0] OP_LW   = 3'd5;
    localparam logic [2:0] OP_LWL  = 3'd6;
    localparam logic [2:0] OP_LWR  = 3'd7;

    logic        ws_valid_q, ws_valid_d;
    logic [31:0] pc_q, pc_d;
    logic [4:0]  dest_q, dest_d;
    logic [31:0] result_q, result_d;
    logic [2:0]  load_op_q, load_op_d;
    logic [1:0]  addr_low_q, addr_low_d;
    logic        data_captured_q, data_captured_d;
    logic [31:0] data_buf_q, data_buf_d;

    logic        ws_ready_go;
    logic        is_load;
    logic [31:0] load_word;
    logic [31:0] byte_shift;
    logic [31:0] half_shift;
    logic [3:0]  strobe_raw;
    logic [31:0] data_raw;

    assign is_load     = (load_op_q != OP_NONE);
    assign ws_ready_go = !is_load | data_captured_q | data_data_ok;
    assign ws_allow_in = !ws_valid_q | ws_ready_go;

    // Next-state logic. A load response is captured into the buffer first;
    // an acceptance on the same edge then overrides it, since a new entry
    // always starts with no captured data.
    always_comb begin
        ws_valid_d      = ws_valid_q;
        pc_d            = pc_q;
        dest_d          = dest_q;
        result_d        = result_q;
        load_op_d       = load_op_q;
        addr_low_d      = addr_low_q;
        data_captured_d = data_captured_q;
        data_buf_d      = data_buf_q;

        if (ws_valid_q && is_load && data_data_ok && !data_captured_q) begin
            data_buf_d      = data_rdata;
            data_captured_d = 1'b1;
        end

        if (ws_allow_in && ms_to_ws_valid) begin
            ws_valid_d      = 1'b1;
            pc_d            = ms_pc;
            dest_d          = ms_dest;
            result_d        = ms_result;
            load_op_d       = ms_load_op;
            addr_low_d      = ms_addr_low;
            data_captured_d = 1'b0;
        end else if (ws_allow_in) begin
            ws_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ws_valid_q      <= 1'b0;
            pc_q            <= PC_RESET;
            dest_q          <= 5'd0;
            result_q        <= 32'd0;
            load_op_q       <= OP_NONE;
            addr_low_q      <= 2'd0;
            data_captured_q <= 1'b0;
            data_buf_q      <= 32'd0;
        end else begin
            ws_valid_q      <= ws_valid_d;
            pc_q            <= pc_d;
            dest_q          <= dest_d;
            result_q        <= result_d;
            load_op_q       <= load_op_d;
            addr_low_q      <= addr_low_d;
            data_captured_q <= data_captured_d;
            data_buf_q      <= data_buf_d;
        end
    end

    // Load alignment. The live response is preferred so a load can write in
    // the same cycle its data arrives; the buffer covers a held response.
    // For LWL/LWR, ~addr_low equals 3-addr_low, giving the merge shift.
    assign load_word  = data_data_ok ? data_rdata : data_buf_q;
    assign byte_shift = load_word >> {addr_low_q, 3'b000};
    assign half_shift = load_word >> {addr_low_q[1], 4'b0000};

    always_comb begin
        strobe_raw = 4'b1111;
        data_raw   = result_q;
        case (load_op_q)
            OP_LB:   data_raw = {{24{byte_shift[7]}}, byte_shift[7:0]};
            OP_LBU:  data_raw = {24'd0, byte_shift[7:0]};
            OP_LH:   data_raw = {{16{half_shift[15]}}, half_shift[15:0]};
            OP_LHU:  data_raw = {16'd0, half_shift[15:0]};
            OP_LW:   data_raw = load_word;
            OP_LWL: begin
                data_raw   = load_word << {~addr_low_q, 3'b000};
                strobe_raw = 4'b1111 << ~addr_low_q;
            end
            OP_LWR: begin
                data_raw   = load_word >> {addr_low_q, 3'b000};
                strobe_raw = 4'b1111 >> addr_low_q;
            end
            default: data_raw = result_q;
        endcase
    end

    // LWL/LWR only merge part of a register, so decode must stall on them
    // rather than forward the partial value.
    assign rf_write_enabled = ws_valid_q & ws_ready_go & (dest_q != 5'd0);
    assign rf_write_address = dest_q;
    assign rf_write_strobe  = rf_write_enabled ? strobe_raw : 4'b0000;
    assign rf_write_data    = data_raw;
    assign ws_bypass_valid  = rf_write_enabled & (load_op_q != OP_LWL) & (load_op_q != OP_LWR);
    assign ws_bypass_dest   = ws_valid_q ? dest_q : 5'd0;
    assign ws_load_pending  = ws_valid_q & is_load & !data_captured_q & !data_data_ok;

`ifdef WRITEBACK_DEBUG_TRACE_EN
    logic [31:0] retired_count_q, retired_count_d;

    // Count one retirement per instruction leaving the stage; wraps naturally.
    always_comb begin
        retired_count_d = retired_count_q;
        if (ws_valid_q && ws_ready_go) begin
            retired_count_d = retired_count_q + 32'd1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            retired_count_q <= 32'd0;
        end else begin
            retired_count_q <= retired_count_d;
        end
    end

    assign debug_wb_pc         = pc_q;
    assign debug_wb_rf_wen     = rf_write_strobe;
    assign debug_wb_rf_wnum    = rf_write_address;
    assign debug_wb_rf_wdata   = rf_write_data;
    assign debug_retired_count = retired_count_q;
`else
    // Without the trace ports the held PC has no consumer.
    logic unused_pc;
    assign unused_pc = ^pc_q;
`endif

endmodule

// File: tb/tb_writeback_stage.sv
// ---------------------------------------------------------------------------
// tb_writeback_stage
//
// Directed testbench for writeback_stage. Inputs change just after the
// falling edge and outputs are sampled 1ns later, well away from the rising
// edge where the stage updates.
// ---------------------------------------------------------------------------
module tb_writeback_stage;

    logic        clock;
    logic        reset_n;
    logic        ms_to_ws_valid;
    logic        ws_allow_in;
    logic [31:0] ms_pc;
    logic [4:0]  ms_dest;
    logic [31:0] ms_result;
    logic [2:0]  ms_load_op;
    logic [1:0]  ms_addr_low;
    logic        data_data_ok;
    logic [31:0] data_rdata;
    logic        rf_write_enabled;
    logic [4:0]  rf_write_address;
    logic [3:0]  rf_write_strobe;
    logic [31:0] rf_write_data;
    logic        ws_bypass_valid;
    logic [4:0]  ws_bypass_dest;
    logic        ws_load_pending;
`ifdef WRITEBACK_DEBUG_TRACE_EN
    logic [31:0] debug_wb_pc;
    logic [3:0]  debug_wb_rf_wen;
    logic [4:0]  debug_wb_rf_wnum;
    logic [31:0] debug_wb_rf_wdata;
    logic [31:0] debug_retired_count;
`endif

    int checks;
    int errors;

    writeback_stage dut (
        .clock            (clock),
        .reset_n          (reset_n),
        .ms_to_ws_valid   (ms_to_ws_valid),
        .ws_allow_in      (ws_allow_in),
        .ms_pc            (ms_pc),
        .ms_dest          (ms_dest),
        .ms_result        (ms_result),
        .ms_load_op       (ms_load_op),
        .ms_addr_low      (ms_addr_low),
        .data_data_ok     (data_data_ok),
        .data_rdata       (data_rdata),
        .rf_write_enabled (rf_write_enabled),
        .rf_write_address (rf_write_address),
        .rf_write_strobe  (rf_write_strobe),
        .rf_write_data    (rf_write_data),
        .ws_bypass_valid  (ws_bypass_valid),
        .ws_bypass_dest   (ws_bypass_dest),
        .ws_load_pending  (ws_load_pending)
`ifdef WRITEBACK_DEBUG_TRACE_EN
        ,
        .debug_wb_pc         (debug_wb_pc),
        .debug_wb_rf_wen     (debug_wb_rf_wen),
        .debug_wb_rf_wnum    (debug_wb_rf_wnum),
        .debug_wb_rf_wdata   (debug_wb_rf_wdata),
        .debug_retired_count (debug_retired_count)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Move to the next sampling point: just after a falling edge.
    task automatic step();
        @(negedge clock);
    endtask

    // Present an instruction (or nothing) from the memory stage.
    task automatic drive_ms(input logic v, input logic [4:0] dest, input logic [31:0] result,
                            input logic [2:0] op, input logic [1:0] a);
        ms_to_ws_valid = v;
        ms_pc          = 32'h0040_0000 + {27'd0, dest};
        ms_dest        = dest;
        ms_result      = result;
        ms_load_op     = op;
        ms_addr_low    = a;
    endtask

    task automatic drive_mem(input logic ok, input logic [31:0] rdata);
        data_data_ok = ok;
        data_rdata   = rdata;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        drive_ms(1'b0, 5'd0, 32'd0, 3'd0, 2'd0);
        drive_mem(1'b0, 32'd0);
        #1;
        checks++; if (ws_allow_in !== 1'b1) begin errors++; $display("[TB] FAIL reset_allow_in: got %b expected 1", ws_allow_in); end
        checks++; if (rf_write_enabled !== 1'b0) begin errors++; $display("[TB] FAIL reset_wen: got %b expected 0", rf_write_enabled); end
        checks++; if (rf_write_address !== 5'd0) begin errors++; $display("[TB] FAIL reset_addr: got %0d expected 0", rf_write_address); end
        checks++; if (rf_write_strobe !== 4'b0000) begin errors++; $display("[TB] FAIL reset_strobe: got %b expected 0000", rf_write_strobe); end
        checks++; if (rf_write_data !== 32'd0) begin errors++; $display("[TB] FAIL reset_data: got %h expected 0", rf_write_data); end
        checks++; if (ws_bypass_valid !== 1'b0 || ws_bypass_dest !== 5'd0 || ws_load_pending !== 1'b0) begin
            errors++; $display("[TB] FAIL reset_hazard: got bv=%b bd=%0d lp=%b expected 0/0/0", ws_bypass_valid, ws_bypass_dest, ws_load_pending); end
        step();
        reset_n = 1'b1;
        step();
    endtask

    task automatic test_non_load();
        drive_ms(1'b1, 5'd5, 32'h1234_5678, 3'd0, 2'd0);
        #1;
        checks++; if (ws_allow_in !== 1'b1) begin errors++; $display("[TB] FAIL nl_allow_empty: got %b expected 1", ws_allow_in); end
        step();
        drive_ms(1'b0, 5'd0, 32'd0, 3'd0, 2'd0);
        #1;
        checks++; if (rf_write_enabled !== 1'b1 || rf_write_address !== 5'd5) begin
            errors++; $display("[TB] FAIL nl_write: got wen=%b addr=%0d expected 1/5", rf_write_enabled, rf_write_address); end
        checks++; if (rf_write_strobe !== 4'b1111 || rf_write_data !== 32'h1234_5678) begin
            errors++; $display("[TB] FAIL nl_data: got strb=%b data=%h expected 1111/12345678", rf_write_strobe, rf_write_data); end
        checks++; if (ws_allow_in !== 1'b1 || ws_bypass_valid !== 1'b1 || ws_bypass_dest !== 5'd5) begin
            errors++; $display("[TB] FAIL nl_bypass: got ai=%b bv=%b bd=%0d expected 1/1/5", ws_allow_in, ws_bypass_valid, ws_bypass_dest); end
        step();
        #1;
        checks++; if (rf_write_enabled !== 1'b0 || ws_bypass_dest !== 5'd0) begin
            errors++; $display("[TB] FAIL nl_empty: got wen=%b bd=%0d expected 0/0", rf_write_enabled, ws_bypass_dest); end
    endtask

    // LB then LBU back to back, each with its data on its first held cycle.
    task automatic test_byte_loads();
        step();
        drive_ms(1'b1, 5'd7, 32'd0, 3'd1, 2'd3);
        step();
        drive_ms(1'b1, 5'd8, 32'd0, 3'd2, 2'd3);
        drive_mem(1'b1, 32'h80AA_BBCC);
        #1;
        checks++; if (rf_write_enabled !== 1'b1 || rf_write_address !== 5'd7 || rf_write_data !== 32'hFFFF_FF80 || rf_write_strobe !== 4'b1111) begin
            errors++; $display("[TB] FAIL lb: got wen=%b addr=%0d strb=%b data=%h expected 1/7/1111/ffffff80", rf_write_enabled, rf_write_address, rf_write_strobe, rf_write_data); end
        checks++; if (ws_allow_in !== 1'b1 || ws_load_pending !== 1'b0) begin
            errors++; $display("[TB] FAIL lb_ready: got ai=%b lp=%b expected 1/0", ws_allow_in, ws_load_pending); end
        step();
        drive_ms(1'b0, 5'd0, 32'd0, 3'd0, 2'd0);
        #1;
        checks++; if (rf_write_enabled !== 1'b1 || rf_write_address !== 5'd8 || rf_write_data !== 32'h0000_0080) begin
            errors++; $display("[TB] FAIL lbu: got wen=%b addr=%0d data=%h expected 1/8/00000080", rf_write_enabled, rf_write_address, rf_write_data); end
        step();
        drive_mem(1'b0, 32'd0);
    endtask

    task automatic test_half_loads();
        drive_ms(1'b1, 5'd3, 32'd0, 3'd3, 2'd3);
        step();
        drive_ms(1'b1, 5'd4, 32'd0, 3'd4, 2'd1);
        drive_mem(1'b1, 32'h8001_7FFF);
        #1;
        checks++; if (rf_write_data !== 32'hFFFF_8001) begin errors++; $display("[TB] FAIL lh_hi: got %h expected ffff8001", rf_write_data); end
        step();
        drive_ms(1'b0, 5'd0, 32'd0, 3'd0, 2'd0);
        #1;
        checks++; if (rf_write_data !== 32'h0000_7FFF) begin errors++; $display("[TB] FAIL lhu_lo: got %h expected 00007fff", rf_write_data); end
        step();
        drive_mem(1'b0, 32'd0);
    endtask

    // LW stalls three cycles; the next instruction waits and enters on the write edge.
    task automatic test_back_to_back();
        drive_ms(1'b1, 5'd9, 32'd0, 3'd5, 2'd0);
        step();
        drive_ms(1'b1, 5'd10, 32'hCAFE_F00D, 3'd0, 2'd0);
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (ws_allow_in !== 1'b0 || ws_load_pending !== 1'b1 || rf_write_enabled !== 1'b0 || rf_write_strobe !== 4'b0000) begin
                errors++; $display("[TB] FAIL lw_stall%0d: got ai=%b lp=%b wen=%b strb=%b expected 0/1/0/0000", i, ws_allow_in, ws_load_pending, rf_write_enabled, rf_write_strobe); end
            checks++; if (ws_bypass_dest !== 5'd9 || ws_bypass_valid !== 1'b0) begin
                errors++; $display("[TB] FAIL lw_stall_bypass%0d: got bd=%0d bv=%b expected 9/0", i, ws_bypass_dest, ws_bypass_valid); end
            step();
        end
        drive_mem(1'b1, 32'hDEAD_BEEF);
        #1;
        checks++; if (rf_write_enabled !== 1'b1 || rf_write_address !== 5'd9 || rf_write_data !== 32'hDEAD_BEEF || ws_allow_in !== 1'b1 || ws_load_pending !== 1'b0) begin
            errors++; $display("[TB] FAIL lw_write: got wen=%b addr=%0d data=%h ai=%b lp=%b expected 1/9/deadbeef/1/0", rf_write_enabled, rf_write_address, rf_write_data, ws_allow_in, ws_load_pending); end
        step();
        drive_mem(1'b0, 32'd0);
        drive_ms(1'b0, 5'd0, 32'd0, 3'd0, 2'd0);
        #1;
        checks++; if (rf_write_enabled !== 1'b1 || rf_write_address !== 5'd10 || rf_write_data !== 32'hCAFE_F00D) begin
            errors++; $display("[TB] FAIL b2b_next: got wen=%b addr=%0d data=%h expected 1/10/cafef00d", rf_write_enabled, rf_write_address, rf_write_data); end
        step();
        #1;
        checks++; if (rf_write_enabled !== 1'b0) begin errors++; $display("[TB] FAIL b2b_single_write: got wen=%b expected 0", rf_write_enabled); end
    endtask

    task automatic test_merge_loads();
        drive_ms(1'b1, 5'd11, 32'd0, 3'd6, 2'd1);
        step();
        drive_ms(1'b1, 5'd12, 32'd0, 3'd7, 2'd2);
        drive_mem(1'b1, 32'h1122_3344);
        #1;
        checks++; if (rf_write_strobe !== 4'b1100 || rf_write_data !== 32'h3344_0000) begin
            errors++; $display("[TB] FAIL lwl: got strb=%b data=%h expected 1100/33440000", rf_write_strobe, rf_write_data); end
        checks++; if (rf_write_enabled !== 1'b1 || ws_bypass_valid !== 1'b0 || ws_bypass_dest !== 5'd11) begin
            errors++; $display("[TB] FAIL lwl_bypass: got wen=%b bv=%b bd=%0d expected 1/0/11", rf_write_enabled, ws_bypass_valid, ws_bypass_dest); end
        step();
        drive_ms(1'b0, 5'd0, 32'd0, 3'd0, 2'd0);
        #1;
        checks++; if (rf_write_strobe !== 4'b0011 || rf_write_data !== 32'h0000_1122 || ws_bypass_valid !== 1'b0) begin
            errors++; $display("[TB] FAIL lwr: got strb=%b data=%h bv=%b expected 0011/00001122/0", rf_write_strobe, rf_write_data, ws_bypass_valid); end
        step();
        drive_mem(1'b0, 32'd0);
    endtask

    task automatic test_dest_zero();
        drive_ms(1'b1, 5'd0, 32'd0, 3'd5, 2'd0);
        step();
        drive_ms(1'b0, 5'd0, 32'd0, 3'd0, 2'd0);
        #1;
        checks++; if (ws_load_pending !== 1'b1) begin errors++; $display("[TB] FAIL d0_pending: got %b expected 1", ws_load_pending); end
        step();
        drive_mem(1'b1, 32'h5555_AAAA);
        #1;
        checks++; if (rf_write_enabled !== 1'b0 || rf_write_strobe !== 4'b0000 || ws_bypass_valid !== 1'b0 || ws_allow_in !== 1'b1) begin
            errors++; $display("[TB] FAIL d0_write: got wen=%b strb=%b bv=%b ai=%b expected 0/0000/0/1", rf_write_enabled, rf_write_strobe, ws_bypass_valid, ws_allow_in); end
        step();
        drive_mem(1'b0, 32'd0);
        #1;
        checks++; if (ws_load_pending !== 1'b0 || ws_allow_in !== 1'b1) begin
            errors++; $display("[TB] FAIL d0_empties: got lp=%b ai=%b expected 0/1", ws_load_pending, ws_allow_in); end
    endtask

    task automatic test_reset_mid_load();
        step();
        drive_ms(1'b1, 5'd13, 32'd0, 3'd5, 2'd0);
        step();
        drive_ms(1'b0, 5'd0, 32'd0, 3'd0, 2'd0);
        #1;
        checks++; if (ws_load_pending !== 1'b1 || ws_allow_in !== 1'b0) begin
            errors++; $display("[TB] FAIL rml_pending: got lp=%b ai=%b expected 1/0", ws_load_pending, ws_allow_in); end
        reset_n = 1'b0;
        #1;
        checks++; if (ws_load_pending !== 1'b0 || ws_allow_in !== 1'b1 || ws_bypass_dest !== 5'd0 || ws_bypass_valid !== 1'b0) begin
            errors++; $display("[TB] FAIL rml_hazard: got lp=%b ai=%b bd=%0d bv=%b expected 0/1/0/0", ws_load_pending, ws_allow_in, ws_bypass_dest, ws_bypass_valid); end
        checks++; if (rf_write_enabled !== 1'b0 || rf_write_address !== 5'd0 || rf_write_strobe !== 4'b0000 || rf_write_data !== 32'd0) begin
            errors++; $display("[TB] FAIL rml_write: got wen=%b addr=%0d strb=%b data=%h expected 0/0/0000/0", rf_write_enabled, rf_write_address, rf_write_strobe, rf_write_data); end
        step();
        reset_n = 1'b1;
        step();
        drive_mem(1'b1, 32'h7777_7777);
        #1;
        checks++; if (rf_write_enabled !== 1'b0 || rf_write_strobe !== 4'b0000 || ws_load_pending !== 1'b0) begin
            errors++; $display("[TB] FAIL rml_late_ok: got wen=%b strb=%b lp=%b expected 0/0000/0", rf_write_enabled, rf_write_strobe, ws_load_pending); end
        step();
        drive_mem(1'b0, 32'd0);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_non_load();
        test_byte_loads();
        test_half_loads();
        test_back_to_back();
        test_merge_loads();
        test_dest_zero();
        test_reset_mid_load();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
